adder_delay_checker: RTL and testbench

- Stimulus generator and result checker for the other end of the registered adder-delay wrapper.
- Drives operands a, b, cin into the wrapper at one vector per cycle.
- Computes the golden a+b+cin internally, aligns it to the wrapper's fixed LAT-cycle latency, and compares it against the returned sum/cout.
- Reports pass/fail, error count and the first failing vector index; used for on-board timing sweeps of wide adders.

---
 rtl/adder_delay_checker.sv | 277 +++++++++++++++++++++++++++
 tb/tb_adder_delay_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_delay_checker.sv
// rtl/adder_delay_checker.sv - stimulus generator and result checker for a registered adder-delay wrapper
//
// Purpose:
//   Issues one operand vector per cycle to a wide adder under test. Indices 0 and 1
//   are directed full-width carry patterns; later indices come from a 32-bit Galois
//   LFSR. A golden a+b+cin is delayed by LAT cycles and compared with the returned
//   {cout_in, sum_in}. Mismatches are counted and the first failing index is kept.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   start         in   one-cycle pulse, accepted only in IDLE
//   num_vectors   in   vectors to issue, sampled on accepted start
//   seed          in   LFSR seed, sampled on accepted start (0 is replaced by 1)
//   a_out, b_out  out  registered operands to the adder under test
//   cin_out       out  registered carry-in to the adder under test
//   sum_in        in   sum returned by the adder under test
//   cout_in       in   carry-out returned by the adder under test
//   busy          out  high in RUN and DRAIN
//   done          out  one-cycle pulse at the end of a run
//   pass          out  last run had no mismatches, held until the next start
//   err_count     out  mismatches in the current/last run, saturating
//   first_err_idx out  index of the first mismatch, all-ones if none
//
// Build option:
//   STOP_ON_ERR_EN  when defined, the first mismatch seen in RUN stops issuing and
//                   moves to DRAIN; vectors already in flight are still checked.

module adder_delay_checker #(
  parameter int W   = 256,
  parameter int LAT = 2,
  parameter int NW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] num_vectors,
  input  logic [31:0]   seed,
  output logic [W-1:0]  a_out,
  output logic [W-1:0]  b_out,
  output logic          cin_out,
  input  logic [W-1:0]  sum_in,
  input  logic          cout_in,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [NW-1:0] err_count,
  output logic [NW-1:0] first_err_idx
);

  localparam int          NREP      = W / 32;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] B_XOR     = 32'h5A5A5A5A;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] nv_q, nv_d;
  logic [NW-1:0] idx_q, idx_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [NW-1:0] err_q, err_d;
  logic [NW-1:0] ferr_q, ferr_d;
  logic [3:0]    drain_q, drain_d;

  // Golden pipeline: stage LAT-1 lines up with the DUT result for the same vector.
  logic          pv_q   [LAT];
  logic [W:0]    pexp_q [LAT];
  logic [NW-1:0] pidx_q [LAT];

  logic [31:0]   seed_eff;
  logic [NW-1:0] issue_idx;
  logic [31:0]   issue_l;
  logic [W-1:0]  gen_a;
  logic [W-1:0]  gen_b;
  logic          gen_cin;
  logic          issue;
  logic          last_vec;
  logic          stop_run;
  logic [W:0]    exp_sum;
  logic          mismatch;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    logic [31:0] n;
    n = {1'b0, l[31:1]};
    if (l[0]) begin
      n = n ^ LFSR_MASK;
    end
    return n;
  endfunction

  assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;

  // The vector loaded at the next edge: index 0 on an accepted start, otherwise
  // the successor of the one currently on the outputs.
  assign issue_idx = (state_q == S_IDLE) ? '0 : idx_q + NW'(1);
  assign issue_l   = (state_q == S_IDLE) ? seed_eff : lfsr_q;

  always_comb begin
    gen_a   = {NREP{issue_l}};
    gen_b   = {NREP{{issue_l[30:0], issue_l[31]} ^ B_XOR}};
    gen_cin = issue_l[0];
    if (issue_idx == '0) begin
      // Carry ripples through every bit position.
      gen_a   = '1;
      gen_b   = '0;
      gen_cin = 1'b1;
    end else if (issue_idx == NW'(1)) begin
      gen_a   = '1;
      gen_b   = '1;
      gen_cin = 1'b1;
    end
  end

  assign exp_sum  = {1'b0, a_q} + {1'b0, b_q} + (W + 1)'(cin_q);
  assign mismatch = pv_q[LAT-1] && ({cout_in, sum_in} != pexp_q[LAT-1]);
  assign last_vec = (idx_q == nv_q - NW'(1));

`ifdef STOP_ON_ERR_EN
  assign stop_run = last_vec || mismatch;
`else
  assign stop_run = last_vec;
`endif

  always_comb begin
    state_d = state_q;
    nv_d    = nv_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    drain_d = drain_q;
    issue   = 1'b0;

    if (mismatch) begin
      if (err_q != '1) begin
        err_d = err_q + NW'(1);
      end
      // err_count never wraps, so zero means no mismatch yet in this run.
      if (err_q == '0) begin
        ferr_d = pidx_q[LAT-1];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nv_d   = num_vectors;
          lfsr_d = seed_eff;
          err_d  = '0;
          ferr_d = '1;
          pass_d = 1'b0;
          if (num_vectors == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            idx_d   = '0;
            issue   = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop_run) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          idx_d = idx_q + NW'(1);
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'(LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      a_d    = gen_a;
      b_d    = gen_b;
      cin_d  = gen_cin;
      lfsr_d = lfsr_step(issue_l);
    end

    // err_d already includes the last in-flight compare when entering DONE.
    if (state_d == S_DONE) begin
      pass_d = (err_d == '0);
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nv_q    <= '0;
      idx_q   <= '0;
      lfsr_q  <= 32'h1;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '1;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      nv_q    <= nv_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      drain_q <= drain_d;
    end
  end

  // Every RUN cycle presents a freshly issued vector, so RUN alone marks stage 0 valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pv_q[i]   <= 1'b0;
        pexp_q[i] <= '0;
        pidx_q[i] <= '0;
      end
    end else begin
      pv_q[0]   <= (state_q == S_RUN);
      pexp_q[0] <= exp_sum;
      pidx_q[0] <= idx_q;
      for (int i = 1; i < LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        pexp_q[i] <= pexp_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
      end
    end
  end

  assign a_out         = a_q;
  assign b_out         = b_q;
  assign cin_out       = cin_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = ferr_q;

endmodule

// File: tb/tb_adder_delay_checker.sv
// tb/tb_adder_delay_checker.sv - self-checking bench for adder_delay_checker
module tb_adder_delay_checker;

  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int NW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] num_vectors = '0;
  logic [31:0]   seed = '0;
  logic [W-1:0]  a_out, b_out, sum_in;
  logic          cin_out, cout_in;
  logic          busy, done, pass;
  logic [NW-1:0] err_count, first_err_idx;

  int tests = 0;
  int fails = 0;
  int fault_mode = 0;

  logic [W-1:0] ra, rb;
  logic         rcin;
  logic [W:0]   rsum;

  logic [2*W:0] exp_vec_q [$];

  adder_delay_checker #(.W(W), .LAT(LAT), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors), .seed(seed),
    .a_out(a_out), .b_out(b_out), .cin_out(cin_out), .sum_in(sum_in), .cout_in(cout_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  // Registered adder wrapper: input stage then output stage (latency 2).
  always @(posedge clk) begin
    ra   <= a_out;
    rb   <= b_out;
    rcin <= cin_out;
    rsum <= {1'b0, ra} + {1'b0, rb} + 33'(rcin);
  end

  always_comb begin
    sum_in  = rsum[W-1:0];
    cout_in = rsum[W];
    if (fault_mode == 1) sum_in[31] = 1'b0;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] l);
    logic [31:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  // Push every expected vector of a run; also count vectors whose golden sum has bit 31 set.
  task automatic push_run(input int nv, input logic [31:0] sd, output int n_bit31);
    logic [31:0]  l;
    logic [W-1:0] va, vb;
    logic         vc;
    logic [W:0]   s;
    n_bit31 = 0;
    l = (sd == 32'h0) ? 32'h1 : sd;
    for (int i = 0; i < nv; i++) begin
      if (i == 0) begin
        va = 32'hFFFFFFFF; vb = 32'h0; vc = 1'b1;
      end else if (i == 1) begin
        va = 32'hFFFFFFFF; vb = 32'hFFFFFFFF; vc = 1'b1;
      end else begin
        va = l; vb = {l[30:0], l[31]} ^ 32'h5A5A5A5A; vc = l[0];
      end
      exp_vec_q.push_back({va, vb, vc});
      s = {1'b0, va} + {1'b0, vb} + 33'(vc);
      if (s[31]) n_bit31++;
      l = m_step(l);
    end
  endtask

  task automatic do_run(input int nv, input logic [31:0] sd, input int restart_at,
                        input logic exp_pass, input int exp_err, input int exp_first);
    int           cyc;
    logic [2*W:0] v;
    @(negedge clk);
    num_vectors = NW'(nv);
    seed        = sd;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    num_vectors = 16'd7;
    seed        = 32'h1234;
    cyc = 0;
    while (busy && cyc < 1000) begin
      if (cyc < nv && exp_vec_q.size() > 0) begin
        v = exp_vec_q.pop_front();
        chk("vector", 80'({a_out, b_out, cin_out}), 80'(v));
      end
      start = (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    exp_vec_q.delete();
    chk("busy_cycles", 80'(cyc), 80'(nv + LAT));
    chk("done_pulse", 80'(done), 80'(1));
    chk("busy_at_done", 80'(busy), 80'(0));
    chk("pass", 80'(pass), 80'(exp_pass));
    chk("err_count", 80'(err_count), 80'(exp_err));
    chk("first_err_idx", 80'(first_err_idx), 80'(exp_first));
    @(negedge clk);
    chk("done_clear", 80'(done), 80'(0));
    chk("pass_hold", 80'(pass), 80'(exp_pass));
  endtask

  initial begin
    int           nb;
    logic [2*W:0] prev;
    int           done_seen;

    repeat (3) @(negedge clk);
    chk("rst_a", 80'(a_out), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    chk("rst_pass", 80'(pass), 80'(0));
    chk("rst_err", 80'(err_count), 80'(0));
    chk("rst_first", 80'(first_err_idx), 80'(16'hFFFF));
    rst_n = 1'b1;

    // Ideal DUT, long run.
    fault_mode = 0;
    push_run(100, 32'hACE1, nb);
    do_run(100, 32'hACE1, -1, 1'b1, 0, 16'hFFFF);

    // Seed 0 maps to 1; a start pulse mid-run must be ignored.
    push_run(20, 32'h0, nb);
    do_run(20, 32'h0, 5, 1'b1, 0, 16'hFFFF);

    // Sum bit 31 stuck at 0: every vector whose golden sum has bit 31 set fails.
    fault_mode = 1;
    push_run(20, 32'h0001_2345, nb);
    do_run(20, 32'h0001_2345, -1, 1'b0, nb, 1);
    chk("fault_min_errs", 80'(nb >= 1), 80'(1));
    fault_mode = 0;

    // Zero vectors: immediate done, operands untouched.
    prev = {a_out, b_out, cin_out};
    @(negedge clk);
    num_vectors = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("nv0_done", 80'(done), 80'(1));
    chk("nv0_busy", 80'(busy), 80'(0));
    chk("nv0_pass", 80'(pass), 80'(1));
    chk("nv0_err", 80'(err_count), 80'(0));
    chk("nv0_first", 80'(first_err_idx), 80'(16'hFFFF));
    chk("nv0_a_hold", 80'({a_out, b_out, cin_out}), 80'(prev));
    @(negedge clk);
    chk("nv0_done_clear", 80'(done), 80'(0));
    chk("nv0_a_hold2", 80'({a_out, b_out, cin_out}), 80'(prev));

    // Reset in the middle of a run.
    @(negedge clk);
    num_vectors = 16'd50;
    seed = 32'hBEEF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 80'(busy), 80'(1));
    rst_n = 1'b0;
    #1;
    chk("async_busy", 80'(busy), 80'(0));
    chk("async_a", 80'({a_out, b_out, cin_out}), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_no_done", 80'(done_seen), 80'(0));
    chk("abort_busy", 80'(busy), 80'(0));
    chk("abort_pass", 80'(pass), 80'(0));
    chk("abort_err", 80'(err_count), 80'(0));
    chk("abort_first", 80'(first_err_idx), 80'(16'hFFFF));
    chk("abort_a", 80'({a_out, b_out, cin_out}), 80'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
